// File: rtl/apb_master_fsm_p.sv
// AHB-to-APB3 transfer controller: one AHB transfer becomes one APB SETUP/ACCESS cycle,
// with PREADY wait states, PSLVERR reporting and an optional ACCESS timeout.
module apb_master_fsm_p #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic            Valid,
  input  logic            Hwrite,
  input  logic [AW-1:0]   Haddr,
  input  logic [NSLV-1:0] Hsel_slv,
  input  logic [DW-1:0]   HWdata,
  output logic            Hreadyout,
  output logic            Hresp,
  output logic [DW-1:0]   HRdata,
  output logic [NSLV-1:0] Pselx,
  output logic            Penable,
  output logic            Pwrite,
  output logic [AW-1:0]   Paddr,
  output logic [DW-1:0]   PWdata,
  input  logic [DW-1:0]   PRdata,
  input  logic            Pready,
  input  logic            Pslverr
);

  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);
  localparam bit   TO_EN   = (TIMEOUT != 0);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [AW-1:0]   addr_reg;
  logic            write_reg;
  logic [NSLV-1:0] sel_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   rdata_reg;
  logic            accept;
  logic            timeout_hit;
  logic            read_done;

  assign accept      = (state_reg == IDLE) && Valid;
  assign timeout_hit = TO_EN && (cnt_reg == TO_LAST);
  assign read_done   = (state_reg == ACCESS) && Pready && !Pslverr && !write_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (Valid) begin
          // A bad decode never reaches the APB bus; it goes straight to the error response.
          if (!$onehot(Hsel_slv)) state_next = ERR1;
          else if (Hwrite)        state_next = WDATA;
          else                    state_next = SETUP;
        end
      end
      WDATA:  state_next = SETUP;
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        // A completing slave wins over the timeout firing in the same cycle.
        if (Pready)           state_next = Pslverr ? ERR1 : IDLE;
        else if (timeout_hit) state_next = ERR1;
        else                  cnt_next   = cnt_reg + 1'b1;
      end
      ERR1:    state_next = ERR2;
      ERR2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      sel_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= Haddr;
        write_reg <= Hwrite;
        sel_reg   <= Hsel_slv;
      end
      if (state_reg == WDATA) wdata_reg <= HWdata;
      if (read_done)          rdata_reg <= PRdata;
    end
  end

  // Every output comes from registered state so nothing combinational reaches the buses.
  assign Hreadyout = (state_reg == IDLE) || (state_reg == ERR2);
  assign Hresp     = (state_reg == ERR1) || (state_reg == ERR2);
  assign Pselx     = ((state_reg == SETUP) || (state_reg == ACCESS)) ? sel_reg : '0;
  assign Penable   = (state_reg == ACCESS);
  assign Pwrite    = write_reg;
  assign Paddr     = addr_reg;
  assign PWdata    = wdata_reg;
  assign HRdata    = rdata_reg;

endmodule

// File: tb/tb_apb_master_fsm_p.sv
// Randomised bench: transfers are expanded into per-cycle expected bus activity from the
// protocol rules, then driven and compared every cycle; directed cases pin key values.
module tb_apb_master_fsm_p;

  localparam int TO = 16;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Valid, Hwrite, Pready, Pslverr;
  logic [31:0] Haddr, HWdata, PRdata;
  logic [3:0]  Hsel_slv;
  logic        Hreadyout, Hresp, Penable, Pwrite;
  logic [31:0] HRdata, Paddr, PWdata;
  logic [3:0]  Pselx;

  logic        nt_valid, nt_hwrite, nt_pready, nt_pslverr;
  logic [31:0] nt_haddr, nt_hwdata, nt_prdata;
  logic [3:0]  nt_hsel;
  logic        nt_hreadyout, nt_hresp, nt_penable, nt_pwrite;
  logic [31:0] nt_hrdata, nt_paddr, nt_pwdata;
  logic [3:0]  nt_pselx;

  always #5 Hclk = ~Hclk;

  apb_master_fsm_p #(.AW(32), .DW(32), .NSLV(4), .TIMEOUT(TO)) u_dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Valid(Valid), .Hwrite(Hwrite), .Haddr(Haddr),
    .Hsel_slv(Hsel_slv), .HWdata(HWdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .HRdata(HRdata), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .PWdata(PWdata), .PRdata(PRdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  apb_master_fsm_p #(.AW(32), .DW(32), .NSLV(4), .TIMEOUT(0)) u_dut_nt (
    .Hclk(Hclk), .Hresetn(Hresetn), .Valid(nt_valid), .Hwrite(nt_hwrite), .Haddr(nt_haddr),
    .Hsel_slv(nt_hsel), .HWdata(nt_hwdata), .Hreadyout(nt_hreadyout), .Hresp(nt_hresp),
    .HRdata(nt_hrdata), .Pselx(nt_pselx), .Penable(nt_penable), .Pwrite(nt_pwrite),
    .Paddr(nt_paddr), .PWdata(nt_pwdata), .PRdata(nt_prdata), .Pready(nt_pready),
    .Pslverr(nt_pslverr)
  );

  typedef struct {
    logic        valid, hwrite, pready, pslverr;
    logic [31:0] haddr, hwdata, prdata;
    logic [3:0]  hsel;
    logic        rdy, resp, pen, pwrite, chk_apb, chk_wd;
    logic [3:0]  psel;
    logic [31:0] paddr, pwdata, hrdata;
  } cyc_t;

  cyc_t        plan_q[$];
  cyc_t        exp_q[$];
  cyc_t        exp_c;
  logic [31:0] model_hrdata = 32'h0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Junk on every input the current cycle must ignore; quiet bus expected by default.
  task automatic base(output cyc_t c);
    c.valid   = 1'($urandom_range(0, 1));
    c.hwrite  = 1'($urandom_range(0, 1));
    c.haddr   = $urandom;
    c.hsel    = 4'($urandom);
    c.hwdata  = $urandom;
    c.prdata  = $urandom;
    c.pready  = 1'($urandom_range(0, 1));
    c.pslverr = 1'($urandom_range(0, 1));
    c.rdy = 0; c.resp = 0; c.pen = 0; c.psel = 0;
    c.chk_apb = 0; c.chk_wd = 0; c.pwrite = 0; c.paddr = 0; c.pwdata = 0;
    c.hrdata = model_hrdata;
  endtask

  task automatic idle_rec();
    cyc_t c;
    base(c);
    c.valid = 0;
    c.rdy   = 1;
    plan_q.push_back(c);
  endtask

  task automatic err_seq();
    cyc_t c;
    base(c); c.resp = 1;             plan_q.push_back(c);
    base(c); c.resp = 1; c.rdy = 1;  plan_q.push_back(c);
  endtask

  task automatic apb_rec(output cyc_t c, input logic [3:0] sel, input logic [31:0] addr,
                         input bit wr, input logic [31:0] wdata, input bit pen);
    base(c);
    c.psel = sel; c.pen = pen; c.chk_apb = 1; c.paddr = addr; c.pwrite = wr;
    c.chk_wd = wr; c.pwdata = wdata;
  endtask

  task automatic plan_xfer(input bit wr, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int waits, input bit err);
    cyc_t c;
    int   nw;
    bit   to;
    $display("xfer wr=%0d sel=%b addr=%h waits=%0d slverr=%0d", wr, sel, addr, waits, err);
    base(c);
    c.valid = 1; c.hwrite = wr; c.haddr = addr; c.hsel = sel; c.rdy = 1;
    plan_q.push_back(c);
    if (!$onehot(sel)) begin
      err_seq();
      return;
    end
    if (wr) begin
      base(c); c.hwdata = wdata; plan_q.push_back(c);
    end
    apb_rec(c, sel, addr, wr, wdata, 0);
    plan_q.push_back(c);
    to = (TO != 0) && (waits >= TO);
    nw = to ? TO : waits;
    for (int i = 0; i < nw; i++) begin
      apb_rec(c, sel, addr, wr, wdata, 1);
      c.pready = 0;
      plan_q.push_back(c);
    end
    if (to) begin
      err_seq();
      return;
    end
    apb_rec(c, sel, addr, wr, wdata, 1);
    c.pready = 1; c.pslverr = err; c.prdata = rdata;
    plan_q.push_back(c);
    if (err) err_seq();
    else if (!wr) model_hrdata = rdata;
  endtask

  task automatic drive(input cyc_t c);
    Valid = c.valid; Hwrite = c.hwrite; Haddr = c.haddr; Hsel_slv = c.hsel;
    HWdata = c.hwdata; PRdata = c.prdata; Pready = c.pready; Pslverr = c.pslverr;
  endtask

  task automatic run_plan(input int n);
    int k = 0;
    while (plan_q.size() != 0 && (n < 0 || k < n)) begin
      cyc_t c = plan_q.pop_front();
      @(posedge Hclk); #1;
      drive(c);
      exp_q.push_back(c);
      k++;
    end
  endtask

  initial forever begin
    @(negedge Hclk);
    if (exp_q.size() != 0) begin
      exp_c = exp_q.pop_front();
      check("Hreadyout", 32'(Hreadyout), 32'(exp_c.rdy));
      check("Hresp",     32'(Hresp),     32'(exp_c.resp));
      check("Pselx",     32'(Pselx),     32'(exp_c.psel));
      check("Penable",   32'(Penable),   32'(exp_c.pen));
      check("HRdata",    HRdata,         exp_c.hrdata);
      if (exp_c.chk_apb) begin
        check("Paddr",  Paddr,          exp_c.paddr);
        check("Pwrite", 32'(Pwrite),    32'(exp_c.pwrite));
      end
      if (exp_c.chk_wd) check("PWdata", PWdata, exp_c.pwdata);
    end
  end

  initial begin
    logic [3:0] s;
    Hresetn = 0;
    Valid = 0; Hwrite = 0; Haddr = 0; Hsel_slv = 0; HWdata = 0; PRdata = 0; Pready = 0; Pslverr = 0;
    nt_valid = 0; nt_hwrite = 0; nt_haddr = 0; nt_hsel = 0; nt_hwdata = 0; nt_prdata = 0;
    nt_pready = 0; nt_pslverr = 0;
    repeat (2) @(posedge Hclk);
    #1;
    check("rst_Hreadyout", 32'(Hreadyout), 32'd1);
    check("rst_Hresp",     32'(Hresp),     32'd0);
    check("rst_Pselx",     32'(Pselx),     32'd0);
    check("rst_Penable",   32'(Penable),   32'd0);
    check("rst_Pwrite",    32'(Pwrite),    32'd0);
    check("rst_Paddr",     Paddr,          32'd0);
    check("rst_PWdata",    PWdata,         32'd0);
    check("rst_HRdata",    HRdata,         32'd0);
    @(negedge Hclk);
    Hresetn = 1;

    plan_xfer(0, 4'b0010, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 0, 0);
    idle_rec();
    check("len_read", 32'(plan_q.size()), 32'd4);
    run_plan(-1);
    @(negedge Hclk); #1;
    check("rd_Hreadyout", 32'(Hreadyout), 32'd1);
    check("rd_HRdata",    HRdata,         32'hCAFE_F00D);

    plan_xfer(1, 4'b0001, 32'h8000_0004, 32'h1234_5678, 32'h0, 3, 0);
    check("len_write_w3", 32'(plan_q.size()), 32'd7);
    idle_rec();
    run_plan(-1);
    @(negedge Hclk); #1;
    check("wr_PWdata", PWdata,       32'h1234_5678);
    check("wr_Hresp",  32'(Hresp),   32'd0);

    plan_xfer(0, 4'b1000, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 0, 1);
    check("len_slverr", 32'(plan_q.size()), 32'd5);
    idle_rec();
    run_plan(-1);
    @(negedge Hclk); #1;
    check("slverr_HRdata_kept", HRdata, 32'hCAFE_F00D);

    plan_xfer(0, 4'b0100, 32'h8000_0030, 32'h0, 32'h1, 40, 0);
    check("len_timeout", 32'(plan_q.size()), 32'd20);
    idle_rec();
    plan_xfer(0, 4'b0100, 32'h8000_0034, 32'h0, 32'h0F0F_0F0F, 15, 0);
    idle_rec();
    run_plan(-1);
    @(negedge Hclk); #1;
    check("edge_ready_beats_timeout", HRdata, 32'h0F0F_0F0F);

    plan_xfer(0, 4'b0000, 32'h8000_0040, 32'h0, 32'h0, 0, 0);
    check("len_badsel", 32'(plan_q.size()), 32'd3);
    plan_xfer(1, 4'b0011, 32'h8000_0044, 32'h5555_AAAA, 32'h0, 0, 0);
    plan_xfer(1, 4'b0010, 32'h8000_0048, 32'hA5A5_5A5A, 32'h0, 0, 0);
    plan_xfer(0, 4'b0001, 32'h8000_004C, 32'h0, 32'h1357_9BDF, 0, 0);
    idle_rec();
    run_plan(-1);

    // Reset in the middle of an ACCESS wait.
    plan_xfer(0, 4'b0100, 32'h8000_0050, 32'h0, 32'h2468_ACE0, 8, 0);
    run_plan(4);
    @(negedge Hclk); #2;
    check("pre_rst_Pselx",   32'(Pselx),   32'b0100);
    check("pre_rst_Penable", 32'(Penable), 32'd1);
    Hresetn = 0;
    #1;
    check("async_Pselx",     32'(Pselx),     32'd0);
    check("async_Penable",   32'(Penable),   32'd0);
    check("async_Hreadyout", 32'(Hreadyout), 32'd1);
    check("async_HRdata",    HRdata,         32'd0);
    plan_q.delete();
    model_hrdata = 32'h0;
    Valid = 0;
    @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1;
    plan_xfer(0, 4'b0010, 32'h8000_0060, 32'h0, 32'h600D_D00D, 1, 0);
    idle_rec();
    run_plan(-1);
    @(negedge Hclk); #1;
    check("post_rst_HRdata", HRdata, 32'h600D_D00D);

    // No-timeout instance: ACCESS must survive well beyond 16 wait cycles.
    @(posedge Hclk); #1;
    nt_valid = 1; nt_hwrite = 0; nt_haddr = 32'h8000_0070; nt_hsel = 4'b0001; nt_pready = 0;
    @(posedge Hclk); #1;
    nt_valid = 0;
    @(negedge Hclk);
    check("nt_setup_Pselx",   32'(nt_pselx),   32'b0001);
    check("nt_setup_Penable", 32'(nt_penable), 32'd0);
    check("nt_setup_Paddr",   nt_paddr,        32'h8000_0070);
    for (int i = 0; i < 40; i++) begin
      @(negedge Hclk);
      check("nt_hold_Penable", 32'(nt_penable), 32'd1);
      check("nt_hold_Pselx",   32'(nt_pselx),   32'b0001);
    end
    @(posedge Hclk); #1;
    nt_pready = 1; nt_prdata = 32'h7777_0000;
    @(posedge Hclk); #1;
    nt_pready = 0;
    @(negedge Hclk);
    check("nt_done_Hreadyout", 32'(nt_hreadyout), 32'd1);
    check("nt_done_HRdata",    nt_hrdata,         32'h7777_0000);
    check("nt_done_Hresp",     32'(nt_hresp),     32'd0);
    check("nt_done_Pwrite",    32'(nt_pwrite),    32'd0);
    check("nt_PWdata",         nt_pwdata,         32'd0);

    // Random traffic, including back-to-back accepts and timeout boundaries.
    for (int t = 0; t < 120; t++) begin
      int r, w;
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 2);
      else if (r < 8) w = $urandom_range(3, 5);
      else if (r < 9) w = $urandom_range(14, 16);
      else            w = $urandom_range(17, 20);
      if ($urandom_range(0, 6) == 0) begin
        do s = 4'($urandom); while ($onehot(s));
      end else begin
        s = 4'b0001 << $urandom_range(0, 3);
      end
      plan_xfer(1'($urandom_range(0, 1)), s, $urandom, $urandom, $urandom, w,
                $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) idle_rec();
    end
    idle_rec();
    run_plan(-1);
    @(negedge Hclk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
